// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator: FSM state encoding,
// link word width and default timing constants.
package spi_pkg;

    localparam int SPI_WORD_W         = 32;
    localparam int SPI_CLK_DIV_DEF    = 4;
    localparam int SPI_GAP_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        GAP
    } spi_state_e;

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable 8-bit down-counter timing one SPI phase.
// done is high on the last cycle of a phase of load_val cycles, so the
// owner changes state on the edge that ends the phase.
module spi_phase_timer
    import spi_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count_q;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 8'd1;
        end
    end

    assign done = (count_q == 8'd1);

endmodule

// File: rtl/spi_master_tx.sv
// SPI initiator, mode 0, MSB first, one DATA_W-bit word per ss_n frame.
// Optional receive path enabled by defining SPI_MASTER_RX_EN: miso is
// sampled on the first cycle of each sclk-high phase and the word is
// presented on rx_data with an rx_valid pulse as ss_n returns high.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int DATA_W     = SPI_WORD_W,
    parameter int CLK_DIV    = SPI_CLK_DIV_DEF,
    parameter int GAP_CYCLES = SPI_GAP_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              ss_n,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid
);

    localparam int              BCW      = $clog2(DATA_W + 1);
    localparam logic [BCW-1:0]  BIT_LAST = BCW'(DATA_W);
    localparam logic [7:0]      DIV_LD   = 8'(CLK_DIV);
    localparam logic [7:0]      GAP_LD   = 8'(GAP_CYCLES);

    spi_state_e        state_q, state_d;
    logic              ss_n_q, ss_n_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic              tmr_load;
    logic [7:0]        tmr_val;
    logic              tmr_done;

    spi_phase_timer u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // State and registered pin drivers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ss_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ss_n_q    <= ss_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state and next-output decode; every phase change reloads the timer.
    always_comb begin
        state_d   = state_q;
        ss_n_d    = ss_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tmr_load  = 1'b0;
        tmr_val   = DIV_LD;
        case (state_q)
            IDLE: begin
                if (tx_valid && ready_q) begin
                    shift_d   = tx_data;
                    bit_cnt_d = '0;
                    ss_n_d    = 1'b0;
                    sclk_d    = 1'b0;
                    mosi_d    = tx_data[DATA_W-1];
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    tmr_load  = 1'b1;
                    state_d   = LEAD;
                end
            end
            LEAD: begin
                if (tmr_done) begin
                    sclk_d   = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = HIGH;
                end
            end
            HIGH: begin
                if (tmr_done) begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    shift_d   = shift_q << 1;
                    mosi_d    = shift_q[DATA_W-2];
                    tmr_load  = 1'b1;
                    state_d   = LOW;
                end
            end
            LOW: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (bit_cnt_q < BIT_LAST) begin
                        sclk_d  = 1'b1;
                        state_d = HIGH;
                    end else begin
                        ss_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                        tmr_val = GAP_LD;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (tmr_done) begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx_ready = ready_q;
    assign busy     = busy_q;
    assign ss_n     = ss_n_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;

`ifdef SPI_MASTER_RX_EN
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              sample_q, sample_d;

    // Receive shift register, output word and first-high-cycle flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sample_q   <= 1'b0;
        end else begin
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sample_q   <= sample_d;
        end
    end

    // Sample once per high phase; publish the word as ss_n rises.
    always_comb begin
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sample_d   = (state_d == HIGH) && (state_q != HIGH);
        if (state_q == HIGH && sample_q) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], miso};
        end
        if (state_q == LOW && state_d == GAP) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`else
    logic unused_miso;

    assign unused_miso = miso;
    assign rx_data     = '0;
    assign rx_valid    = 1'b0;
`endif

endmodule
